// File: rtl/note_recorder_pkg.sv
// Shared types and constants for the note recorder block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: note field widths, reset defaults, packed note entry, FSM state encoding.
package note_recorder_pkg;

  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS   = 4;
  localparam int LENGTH_BITS = 3;
  localparam int ENTRY_BITS  = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

  localparam logic [OCTAVE_BITS-1:0] DEFAULT_OCTAVE = 3'b100;
  localparam logic [NOTE_BITS-1:0]   REST_NOTE      = '0;

  // One buffered note, as captured from the key decoder.
  typedef struct packed {
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] length;
  } note_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC,
    ST_PLAY_ISSUE,
    ST_PLAY_BUSY,
    ST_PLAY_DONE
  } state_t;

endpackage

// File: rtl/note_recorder_if.sv
// Note bus between key decoder (writer), recorder and sound generator (reader).
// Latency: n/a (wires only).
// Backpressure: snd_over from the generator gates the next snd_start.
// Ports: hit_* carries decoded notes in, snd_* carries replayed notes out.
interface note_recorder_if;
  import note_recorder_pkg::*;

  logic                   hit_valid;
  logic [OCTAVE_BITS-1:0] hit_octave;
  logic [NOTE_BITS-1:0]   hit_note;
  logic [LENGTH_BITS-1:0] hit_length;

  logic                   snd_over;
  logic                   snd_start;
  logic [OCTAVE_BITS-1:0] snd_octave;
  logic [NOTE_BITS-1:0]   snd_note;
  logic [LENGTH_BITS-1:0] snd_length;

  // Recorder side.
  modport slave (
    input  hit_valid, hit_octave, hit_note, hit_length, snd_over,
    output snd_start, snd_octave, snd_note, snd_length
  );

  // Environment side: decoder plus sound generator.
  modport master (
    output hit_valid, hit_octave, hit_note, hit_length, snd_over,
    input  snd_start, snd_octave, snd_note, snd_length
  );

endinterface

// File: rtl/note_buffer.sv
// Song storage: DEPTH x note_t register array.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; the caller guards writes against overflow.
// Ports: clk, wr_en/wr_addr/wr_data write port, rd_addr/rd_data read port.
module note_buffer
  import note_recorder_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int PTR_BITS = 6
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PTR_BITS-1:0] wr_addr,
  input  note_t               wr_data,
  input  logic [PTR_BITS-1:0] rd_addr,
  output note_t               rd_data
);

  // Contents survive reset on purpose: only the entry count is cleared.
  note_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_recorder.sv
// Records decoded notes into a song buffer and replays them to the sound generator.
// Latency: hit stored next cycle; snd_start 2 cycles after snd_over rises between notes.
// Backpressure: replay holds in PLAY_BUSY until the generator reports snd_over.
// Ports: clk/rst_n (sync, active-high), rec/play control pulses, loop level,
//        note bus (bus), status recording/playing/full/count/play_idx/done.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int PTR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rec_start,
  input  logic                rec_stop,
  input  logic                play_start,
  input  logic                play_stop,
  input  logic                loop,
  note_recorder_if.slave      bus,
  output logic                recording,
  output logic                playing,
  output logic                full,
  output logic [PTR_BITS:0]   count,
  output logic [PTR_BITS-1:0] play_idx,
  output logic                done
);

  localparam logic [PTR_BITS:0]   CNT_ONE    = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] IDX_ONE    = PTR_BITS'(1);

  state_t              state;
  logic                busy_first;
  logic                wr_en;
  logic                last_entry;
  logic [PTR_BITS-1:0] rd_addr;
  note_t               wr_data;
  note_t               rd_data;

  assign full       = (count == FULL_COUNT);
  assign recording  = (state == ST_REC);
  assign playing    = (state == ST_PLAY_ISSUE) || (state == ST_PLAY_BUSY) ||
                      (state == ST_PLAY_DONE);
  assign last_entry = ({1'b0, play_idx} == (count - CNT_ONE));

  // A rec_start in the same cycle restarts the song, so that hit is not kept
  // unless rec_stop (higher priority) cancels the restart.
  assign wr_en   = (state == ST_REC) && bus.hit_valid && !full &&
                   (rec_stop || !rec_start);
  assign wr_data = '{octave: bus.hit_octave, note: bus.hit_note, length: bus.hit_length};

  // Read address is the index about to be issued, so snd_* can be loaded on
  // the same edge that enters PLAY_ISSUE.
  assign rd_addr = (state == ST_PLAY_DONE && !last_entry) ? (play_idx + IDX_ONE) : '0;

  note_buffer #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[PTR_BITS-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state          <= ST_IDLE;
      busy_first     <= 1'b0;
      count          <= '0;
      play_idx       <= '0;
      done           <= 1'b0;
      bus.snd_start  <= 1'b0;
      bus.snd_octave <= DEFAULT_OCTAVE;
      bus.snd_note   <= REST_NOTE;
      bus.snd_length <= '0;
    end else begin
      bus.snd_start <= 1'b0;
      done          <= 1'b0;
      if (wr_en) begin
        count <= count + CNT_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (rec_stop || play_stop) begin
            state <= ST_IDLE;
          end else if (rec_start) begin
            count <= '0;
            state <= ST_REC;
          end else if (play_start) begin
            if (count != '0) begin
              play_idx       <= '0;
              bus.snd_start  <= 1'b1;
              bus.snd_octave <= rd_data.octave;
              bus.snd_note   <= rd_data.note;
              bus.snd_length <= rd_data.length;
              state          <= ST_PLAY_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end

        ST_REC: begin
          if (rec_stop) begin
            state <= ST_IDLE;
          end else if (rec_start) begin
            count <= '0;
          end
        end

        ST_PLAY_ISSUE: begin
          if (play_stop) begin
            state <= ST_IDLE;
          end else begin
            busy_first <= 1'b1;
            state      <= ST_PLAY_BUSY;
          end
        end

        ST_PLAY_BUSY: begin
          busy_first <= 1'b0;
          if (play_stop) begin
            state <= ST_IDLE;
          end else if (!busy_first && bus.snd_over) begin
            // First BUSY cycle is skipped: snd_over is still high from the
            // previous note until the generator reacts to snd_start.
            state <= ST_PLAY_DONE;
          end
        end

        ST_PLAY_DONE: begin
          if (play_stop) begin
            state <= ST_IDLE;
          end else if (last_entry && !loop) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            play_idx       <= last_entry ? '0 : (play_idx + IDX_ONE);
            bus.snd_start  <= 1'b1;
            bus.snd_octave <= rd_data.octave;
            bus.snd_note   <= rd_data.note;
            bus.snd_length <= rd_data.length;
            state          <= ST_PLAY_ISSUE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: song model queue plus a sound generator model.
// Latency: n/a.
// Backpressure: generator holds snd_over low for a fixed or random time per note.
module tb_note_recorder;
  import note_recorder_pkg::*;

  localparam int DEPTH    = 64;
  localparam int PTR_BITS = 6;

  typedef struct {
    int         cyc;
    note_t      n;
    logic [5:0] idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rec_start = 1'b0, rec_stop = 1'b0, play_start = 1'b0, play_stop = 1'b0;
  logic       loop = 1'b0;
  logic       recording, playing, full, done;
  logic [6:0] count;
  logic [5:0] play_idx;

  note_recorder_if bus();

  note_recorder #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop       (loop),
    .bus        (bus),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .count      (count),
    .play_idx   (play_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  int    checks = 0, failures = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    busy_fixed = 10;
  int    rise_cyc = 0;
  bit    rise_pending = 0;
  note_t song[$];
  ev_t   issued[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor plus sound generator model; all sampling on the falling edge.
  initial begin
    int  gen_cnt;
    ev_t e;
    gen_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        rise_pending = 0;
      end
      if (bus.snd_start) begin
        e.cyc = cyc;
        e.n   = '{octave: bus.snd_octave, note: bus.snd_note, length: bus.snd_length};
        e.idx = play_idx;
        issued.push_back(e);
        if (rise_pending) begin
          check_eq("note_gap", cyc - rise_cyc, 2);
          rise_pending = 0;
        end
        bus.snd_over = 1'b0;
        gen_cnt = (busy_fixed != 0) ? busy_fixed : $urandom_range(2, 10);
      end else if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) begin
          bus.snd_over = 1'b1;
          rise_cyc     = cyc;
          rise_pending = 1;
        end
      end
    end
  end

  task automatic start_rec();
    rec_start = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
    song.delete();
  endtask

  task automatic stop_rec();
    rec_stop = 1'b1;
    @(negedge clk);
    rec_stop = 1'b0;
  endtask

  task automatic hit(input logic [2:0] o, input logic [3:0] n, input logic [2:0] l,
                     input bit store, input bit with_stop);
    bus.hit_valid  = 1'b1;
    bus.hit_octave = o;
    bus.hit_note   = n;
    bus.hit_length = l;
    rec_stop       = with_stop;
    @(negedge clk);
    bus.hit_valid = 1'b0;
    rec_stop      = 1'b0;
    if (store && song.size() < DEPTH) song.push_back('{octave: o, note: n, length: l});
  endtask

  task automatic rand_hit(input bit store, input bit with_stop);
    hit(3'($urandom), 4'($urandom_range(0, 7)), 3'($urandom), store, with_stop);
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1;
    end
    check_eq({tag, "_done_seen"}, seen, 1);
  endtask

  // Expected replay: entry i of the song in order, wrapping for loop mode.
  task automatic verify_play(input string tag, input int n_exp);
    int k;
    check_eq({tag, "_starts"}, issued.size(), n_exp);
    for (int i = 0; i < issued.size() && i < n_exp; i++) begin
      k = i % song.size();
      check_eq({tag, "_idx"},    issued[i].idx, k);
      check_eq({tag, "_octave"}, issued[i].n.octave, song[k].octave);
      check_eq({tag, "_note"},   issued[i].n.note,   song[k].note);
      check_eq({tag, "_length"}, issued[i].n.length, song[k].length);
    end
  endtask

  initial begin
    int  d0, n;
    bit  seen;
    bus.hit_valid  = 1'b0;
    bus.hit_octave = '0;
    bus.hit_note   = '0;
    bus.hit_length = '0;
    bus.snd_over   = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_count", count, 0);
    check_eq("rst_play_idx", play_idx, 0);
    check_eq("rst_snd_start", bus.snd_start, 0);
    check_eq("rst_snd_octave", bus.snd_octave, 4);
    check_eq("rst_snd_note", bus.snd_note, 0);
    check_eq("rst_snd_length", bus.snd_length, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_recording", recording, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_full", full, 0);
    rst_n = 1'b0;
    @(negedge clk);

    // Directed three-note song, generator busy 10 cycles per note.
    busy_fixed = 10;
    start_rec();
    check_eq("rec_recording", recording, 1);
    hit(3'd4, 4'd1, 3'd2, 1, 0);
    hit(3'd5, 4'd3, 3'd1, 1, 0);
    hit(3'd3, 4'd7, 3'd4, 1, 0);
    stop_rec();
    check_eq("dir_count", count, 3);
    issued.delete();
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    wait_done("dir", d0, 200);
    repeat (5) @(negedge clk);
    verify_play("dir", 3);
    check_eq("dir_done_once", done_cnt - d0, 1);
    check_eq("dir_count_after", count, 3);

    // Random song; last hit coincides with rec_stop; hits during replay ignored.
    busy_fixed = 0;
    start_rec();
    n = $urandom_range(4, 12);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_hit(1, i == n - 1);
    end
    check_eq("rnd_recording_off", recording, 0);
    check_eq("rnd_count", count, song.size());
    issued.delete();
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (3) rand_hit(0, 0);
    wait_done("rnd", d0, 400);
    repeat (5) @(negedge clk);
    verify_play("rnd", song.size());
    check_eq("rnd_play_hits_ignored", count, song.size());
    check_eq("rnd_done_once", done_cnt - d0, 1);

    // Fill past capacity; overflow hits dropped.
    busy_fixed = 2;
    start_rec();
    repeat (DEPTH + 2) rand_hit(1, 0);
    check_eq("fill_full", full, 1);
    check_eq("fill_count", count, DEPTH);
    stop_rec();
    issued.delete();
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    wait_done("fill", d0, 2000);
    repeat (5) @(negedge clk);
    verify_play("fill", DEPTH);

    // Loop mode with two entries, then abort during a BUSY phase.
    busy_fixed = 10;
    start_rec();
    rand_hit(1, 0);
    rand_hit(1, 0);
    stop_rec();
    loop = 1'b1;
    issued.delete();
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (issued.size() >= 4) seen = 1;
    end
    check_eq("loop_reached_4", seen, 1);
    @(negedge clk);
    check_eq("loop_busy_playing", playing, 1);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    check_eq("loop_stop_idle", playing, 0);
    check_eq("loop_stop_snd_start", bus.snd_start, 0);
    repeat (30) @(negedge clk);
    loop = 1'b0;
    rise_pending = 0;
    verify_play("loop", 4);
    check_eq("loop_no_done", done_cnt - d0, 0);

    // Empty song: no note, single done. Then rec_start beats play_start.
    start_rec();
    stop_rec();
    check_eq("empty_count", count, 0);
    issued.delete();
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("empty_done_once", done_cnt - d0, 1);
    check_eq("empty_no_start", issued.size(), 0);
    check_eq("empty_idle", playing, 0);
    rec_start  = 1'b1;
    play_start = 1'b1;
    @(negedge clk);
    rec_start  = 1'b0;
    play_start = 1'b0;
    check_eq("prio_recording", recording, 1);
    check_eq("prio_not_playing", playing, 0);
    stop_rec();

    // Reset asserted while PLAY_BUSY.
    start_rec();
    rand_hit(1, 0);
    rand_hit(1, 0);
    stop_rec();
    issued.delete();
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (issued.size() >= 1) seen = 1;
    end
    check_eq("mrst_started", seen, 1);
    @(negedge clk);
    check_eq("mrst_busy_playing", playing, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_eq("mrst_playing", playing, 0);
    check_eq("mrst_recording", recording, 0);
    check_eq("mrst_count", count, 0);
    check_eq("mrst_snd_start", bus.snd_start, 0);
    check_eq("mrst_snd_octave", bus.snd_octave, 4);
    repeat (15) @(negedge clk);
    rise_pending = 0;
    check_eq("mrst_no_more_starts", issued.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
